// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : bit-counter width for a given operand width, never below 1
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Host-side handshake and data bus of the bit-serial adder.
//   start, a, b, cin : request and operands (host -> adder)
//   busy, done       : status; done is a one-cycle result-valid pulse
//   sum, cout        : registered result, held until the next completion
// Modports: master = host, slave = adder.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl_fulladder.sv
// 1-bit full adder cell.
//   A, B, Cin : addend bits and carry-in
//   S, Cout   : sum bit and carry-out
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one fulladder cell is sequenced over WIDTH
// cycles to form {cout,sum} = a + b + cin.
//   clk, rst : clock (rising edge) and synchronous active-high reset
//   bus      : slave side of serial_adder_ctrl_if (start/a/b/cin in,
//              busy/done/sum/cout out)
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic [WIDTH-1:0] ss_nx;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             fa_s;
    logic             fa_cout;

    fulladder u_fa (
        .A    (sa[0]),
        .B    (sb[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Shift-in of the new sum bit at the MSB; written this way so WIDTH=1
    // needs no special-case slice.
    always_comb begin
        ss_nx            = ss >> 1;
        ss_nx[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (bus.start) state_nx = ST_RUN;
            ST_RUN:  if (last)      state_nx = ST_DONE;
            ST_DONE:                state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            ss     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    ss    <= ss_nx;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum_q  <= ss_nx;
                        cout_q <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_sum8  = 8'h00;
    logic       exp_cout8 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge with the WIDTH=8 adder idle; returns at the
    // negedge of the IDLE cycle following the done pulse.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input bit poke);
        logic [8:0] exp;
        exp = 9'(av) + 9'(bv) + 9'(cv);
        bus8.start = 1'b1;
        bus8.a     = av;
        bus8.b     = bv;
        bus8.cin   = cv;
        @(negedge clk);
        bus8.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("busy8_run", 32'(bus8.busy), 32'd1);
            check("done8_early", 32'(bus8.done), 32'd0);
            check("sum8_hold", 32'(bus8.sum), 32'(exp_sum8));
            check("cout8_hold", 32'(bus8.cout), 32'(exp_cout8));
            // operands may change freely once accepted
            bus8.a   = 8'($urandom);
            bus8.b   = 8'($urandom);
            bus8.cin = 1'($urandom);
            bus8.start = (poke && i == 3) ? 1'b1 : 1'b0;
            if (poke && i == 3) bus8.a = 8'hFF;
            @(negedge clk);
        end
        bus8.start = 1'b0;
        check("done8", 32'(bus8.done), 32'd1);
        check("busy8_done", 32'(bus8.busy), 32'd0);
        check("sum8", 32'(bus8.sum), 32'(exp[7:0]));
        check("cout8", 32'(bus8.cout), 32'(exp[8]));
        exp_sum8  = exp[7:0];
        exp_cout8 = exp[8];
        @(negedge clk);
        check("done8_pulse", 32'(bus8.done), 32'd0);
        check("busy8_idle", 32'(bus8.busy), 32'd0);
    endtask

    logic [7:0] oa [50];
    logic [7:0] ob [50];
    logic       oc [50];

    initial begin
        logic [8:0] e9;
        logic [1:0] e1;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy8", 32'(bus8.busy), 32'd0);
        check("rst_done8", 32'(bus8.done), 32'd0);
        check("rst_sum8", 32'(bus8.sum), 32'd0);
        check("rst_cout8", 32'(bus8.cout), 32'd0);
        check("rst_busy1", 32'(bus1.busy), 32'd0);
        check("rst_done1", 32'(bus1.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_op8(8'h0F, 8'h01, 1'b0, 1'b0);
        check("t1_sum", 32'(bus8.sum), 32'h10);
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0);
        check("t2a_cout", 32'(bus8.cout), 32'd1);
        run_op8(8'hFF, 8'hFF, 1'b1, 1'b0);
        check("t2b_sum", 32'(bus8.sum), 32'hFF);
        run_op8(8'h12, 8'h34, 1'b0, 1'b1);
        check("t3_sum", 32'(bus8.sum), 32'h46);

        // reset in RUN cycle 4 abandons the operation
        bus8.start = 1'b1; bus8.a = 8'hA5; bus8.b = 8'h5A; bus8.cin = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_busy", 32'(bus8.busy), 32'd0);
        check("t4_done", 32'(bus8.done), 32'd0);
        check("t4_sum", 32'(bus8.sum), 32'd0);
        check("t4_cout", 32'(bus8.cout), 32'd0);
        exp_sum8 = 8'h00; exp_cout8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("t4_no_done", 32'(bus8.done), 32'd0);
            @(negedge clk);
        end
        run_op8(8'h3C, 8'h44, 1'b1, 1'b0);

        // start held high: period of WIDTH+2 = 10 cycles; accept at end of
        // cycles 0,10,20..., done in cycles 9,19,29...
        bus8.start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            check("t5_busy", 32'(bus8.busy), 32'((c % 10 >= 1) && (c % 10 <= 8)));
            if (c % 10 == 9) begin
                e9 = 9'(oa[c-9]) + 9'(ob[c-9]) + 9'(oc[c-9]);
                check("t5_done", 32'(bus8.done), 32'd1);
                check("t5_sum", 32'(bus8.sum), 32'(e9[7:0]));
                check("t5_cout", 32'(bus8.cout), 32'(e9[8]));
                exp_sum8 = e9[7:0]; exp_cout8 = e9[8];
            end else begin
                check("t5_nodone", 32'(bus8.done), 32'd0);
                check("t5_sum_hold", 32'(bus8.sum), 32'(exp_sum8));
                check("t5_cout_hold", 32'(bus8.cout), 32'(exp_cout8));
            end
            oa[c] = 8'($urandom); ob[c] = 8'($urandom); oc[c] = 1'($urandom);
            bus8.a = oa[c]; bus8.b = ob[c]; bus8.cin = oc[c];
            @(negedge clk);
        end
        bus8.start = 1'b0;
        @(negedge clk);

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            bus1.start = 1'b1;
            bus1.a   = 1'(i);
            bus1.b   = 1'(i >> 1);
            bus1.cin = 1'(i >> 2);
            e1 = 2'(i & 1) + 2'((i >> 1) & 1) + 2'((i >> 2) & 1);
            @(negedge clk);
            bus1.start = 1'b0;
            check("w1_busy", 32'(bus1.busy), 32'd1);
            check("w1_early", 32'(bus1.done), 32'd0);
            @(negedge clk);
            check("w1_done", 32'(bus1.done), 32'd1);
            check("w1_result", 32'({bus1.cout, bus1.sum}), 32'(e1));
            @(negedge clk);
            check("w1_pulse", 32'(bus1.done), 32'd0);
        end

        // random operands on WIDTH=8
        for (int i = 0; i < 20; i++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
